gemm_skew_feeder: RTL and testbench

GEMM_SKEW_FEEDER -- requirements
Module: gemm_skew_feeder

---
 rtl/gemm_skew_feeder.sv | 129 ++++++++++++
 tb/tb_gemm_skew_feeder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/gemm_skew_feeder.sv
// Operand skew feeder for an N x N systolic GEMM array: accepts K-step A/B beats and
// delays lane i by i+1 cycles. Optional stall counter under GEMM_FEEDER_STALL_CNT_EN.
module gemm_skew_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              k_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] a_vec,
  input  logic [N*DATA_WIDTH-1:0] b_vec,
  output logic [N*DATA_WIDTH-1:0] a_out,
  output logic [N*DATA_WIDTH-1:0] b_out,
  output logic [N-1:0]            lane_valid,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             stall_count
);

  localparam int FW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t        r_state;
  logic [7:0]    r_k_len;
  logic [7:0]    r_beat_cnt;
  logic [FW-1:0] r_flush_cnt;
  logic          w_accept;
  logic          w_last;

  assign w_accept = (r_state == LOAD) && in_valid;
  assign w_last   = w_accept && ((r_beat_cnt + 8'd1) == r_k_len);

  assign in_ready = (r_state == LOAD);
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_k_len    <= k_len;
            r_beat_cnt <= '0;
            r_state    <= (k_len == 8'd0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
          end
          if (w_last) begin
            r_flush_cnt <= '0;
            r_state     <= FLUSH;
          end
        end
        FLUSH: begin
          // N cycles lets the deepest lane drain the final beat.
          if (r_flush_cnt == FW'(N - 1)) begin
            r_state <= DONE;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Lane i: chain of i+1 registers; bubbles enter as zero with valid low in both chains.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] r_a_p [0:i];
    logic signed [DATA_WIDTH-1:0] r_b_p [0:i];
    logic                         r_vld_p [0:i];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int d = 0; d <= i; d++) begin
          r_a_p[d]   <= '0;
          r_b_p[d]   <= '0;
          r_vld_p[d] <= 1'b0;
        end
      end else begin
        r_a_p[0]   <= w_accept ? a_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        r_b_p[0]   <= w_accept ? b_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        r_vld_p[0] <= w_accept;
        for (int d = 1; d <= i; d++) begin
          r_a_p[d]   <= r_a_p[d-1];
          r_b_p[d]   <= r_b_p[d-1];
          r_vld_p[d] <= r_vld_p[d-1];
        end
      end
    end

    assign a_out[i*DATA_WIDTH +: DATA_WIDTH] = r_a_p[i];
    assign b_out[i*DATA_WIDTH +: DATA_WIDTH] = r_b_p[i];
    assign lane_valid[i]                     = r_vld_p[i];
  end

`ifdef GEMM_FEEDER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_stall_cnt <= '0;
    end else if ((r_state == LOAD) && !in_valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_count = r_stall_cnt;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_gemm_skew_feeder.sv
// Table-driven bench for gemm_skew_feeder (N=4, DATA_WIDTH=8); per-cycle scoreboard of
// accepted beats predicts the skewed lanes.
module tb_gemm_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 8;

`ifdef GEMM_FEEDER_STALL_CNT_EN
  localparam int EXP_STALL1 = 1;
`else
  localparam int EXP_STALL1 = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    k_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   a_vec = '0;
  logic [31:0]   b_vec = '0;
  logic [31:0]   a_out;
  logic [31:0]   b_out;
  logic [N-1:0]  lane_valid;
  logic          busy;
  logic          done;
  logic [15:0]   stall_count;

  always #5 clk = ~clk;

  gemm_skew_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .k_len       (k_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_vec       (a_vec),
    .b_vec       (b_vec),
    .a_out       (a_out),
    .b_out       (b_out),
    .lane_valid  (lane_valid),
    .busy        (busy),
    .done        (done),
    .stall_count (stall_count)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic [7:0]  k;
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic        acc;
    logic        bz;
    logic        rd;
    logic        dn;
    int          stall;
  } vec_t;

  typedef struct {
    logic        acc;
    logic [31:0] a;
    logic [31:0] b;
  } hist_t;

  vec_t  tbl[$];
  hist_t hist[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic add(input logic rst, input logic st, input logic [7:0] k, input logic v,
                     input logic [31:0] a, input logic [31:0] b, input logic acc,
                     input logic bz, input logic rd, input logic dn, input int stall);
    vec_t r;
    r.rst = rst; r.st = st; r.k = k; r.v = v; r.a = a; r.b = b;
    r.acc = acc; r.bz = bz; r.rd = rd; r.dn = dn; r.stall = stall;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Shorthands: idle cycle, load beat, flush cycle (in_valid high but must be ignored).
  task automatic idle(input int n, input int stall);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (i == n-1) ? stall : -1);
  endtask
  task automatic beat(input logic [31:0] a, input logic [31:0] b);
    add(0, 0, 0, 1, a, b, 1, 1, 1, 0, -1);
  endtask
  task automatic flush(input int n);
    for (int i = 0; i < n; i++) add(0, 0, 0, 1, 32'hDEADBEEF, 32'hCAFEF00D, 0, 1, 0, 0, -1);
  endtask

  initial begin
    logic [31:0]  ea, eb;
    logic [N-1:0] ev;
    hist_t        h;

    // reset state, then in_valid while IDLE must not be consumed
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 32'hDEADBEEF, 32'h01020304, 0, 0, 0, 0, -1);
    // k_len=3 back-to-back, a == b
    add(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, -1);
    beat(32'h04030201, 32'h04030201);
    beat(32'h08070605, 32'h08070605);
    beat(32'h0C0B0A09, 32'h0C0B0A09);
    flush(4);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, -1);
    idle(2, 0);
    // k_len=2 with one bubble between beats
    add(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, -1);
    beat(32'h11223344, 32'hA5B6C7D8);
    add(0, 0, 0, 0, 32'h99999999, 32'h99999999, 0, 1, 1, 0, -1);
    beat(32'h55667788, 32'h192A3B4C);
    flush(4);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, -1);
    idle(2, EXP_STALL1);
    // k_len=0: straight to DONE; honoured start also clears the stall count
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, -1);
    idle(4, 0);
    // k_len=4, reset during second FLUSH cycle: everything discarded, no done
    add(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, -1);
    beat(32'h10203040, 32'hFF00FF00);
    beat(32'h50607080, 32'h00FF00FF);
    beat(32'h90A0B0C0, 32'h12345678);
    beat(32'hD0E0F001, 32'h9ABCDEF0);
    flush(1);
    add(1, 0, 0, 1, 32'hDEADBEEF, 32'hCAFEF00D, 0, 1, 0, 0, -1);
    idle(6, 0);
    // k_len=5 with a start pulse mid-LOAD (ignored) and negative operands
    add(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, -1);
    beat(32'h80808080, 32'h80808080);
    add(0, 1, 2, 1, 32'hFF80017F, 32'h7F0180FF, 1, 1, 1, 0, -1);
    beat(32'h80FF8001, 32'h01800080);
    beat(32'hFEDCBA98, 32'h80000080);
    beat(32'h7F7F8080, 32'h80807F7F);
    flush(4);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, -1);
    idle(4, 0);

    for (int i = 0; i < N; i++) begin
      h.acc = 1'b0; h.a = '0; h.b = '0;
      hist.push_back(h);
    end

    repeat (2) @(posedge clk);

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      // hist[i] holds the beat driven i+1 cycles ago, which lane i must show now
      for (int l = 0; l < N; l++) begin
        ev[l]            = hist[l].acc;
        ea[l*DW +: DW]   = hist[l].acc ? hist[l].a[l*DW +: DW] : 8'h00;
        eb[l*DW +: DW]   = hist[l].acc ? hist[l].b[l*DW +: DW] : 8'h00;
      end
      chk("a_out",      r, a_out, ea);
      chk("b_out",      r, b_out, eb);
      chk("lane_valid", r, {28'd0, lane_valid}, {28'd0, ev});
      chk("busy",       r, {31'd0, busy},     {31'd0, tbl[r].bz});
      chk("in_ready",   r, {31'd0, in_ready}, {31'd0, tbl[r].rd});
      chk("done",       r, {31'd0, done},     {31'd0, tbl[r].dn});
      if (tbl[r].stall >= 0)
        chk("stall_count", r, {16'd0, stall_count}, tbl[r].stall);

      reset    = tbl[r].rst;
      start    = tbl[r].st;
      k_len    = tbl[r].k;
      in_valid = tbl[r].v;
      a_vec    = tbl[r].a;
      b_vec    = tbl[r].b;

      if (tbl[r].rst) begin
        for (int i = 0; i < N; i++) begin
          hist[i].acc = 1'b0; hist[i].a = '0; hist[i].b = '0;
        end
      end else begin
        h.acc = tbl[r].acc; h.a = tbl[r].a; h.b = tbl[r].b;
        hist.push_front(h);
        void'(hist.pop_back());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
